// File: rtl/counter_cmd_sched.sv
// Round-robin scheduler that shares one up/down counter between two requesters.
// Each command loads a start value, counts toward its target and pulses a completion report.
module counter_cmd_sched #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_start,
    input  logic [2*WIDTH-1:0] req_target,
    output logic               cnt_enable,
    output logic               cnt_load,
    output logic               cnt_up_down_n,
    output logic [WIDTH-1:0]   cnt_data_input,
    input  logic [WIDTH-1:0]   cnt_data_output,
    output logic               done_valid,
    output logic               done_id,
    output logic [WIDTH-1:0]   done_value,
    output logic               done_err
);
    typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_e;

    localparam logic [WIDTH:0] WD_LIMIT = {1'b1, {WIDTH{1'b0}}};

    state_e           state_q;
    logic             rr_q;
    logic             id_q;
    logic             dir_q;
    logic             err_q;
    logic [WIDTH-1:0] start_q;
    logic [WIDTH-1:0] target_q;
    logic [WIDTH:0]   wd_q;

    logic             any_valid;
    logic             grant_id;
    logic             at_target;
    logic             wd_expired;
    logic [WIDTH-1:0] grant_start;
    logic [WIDTH-1:0] grant_target;

    assign any_valid    = |req_valid;
    // The pointer index wins when it is requesting; otherwise the other requester does.
    assign grant_id     = req_valid[rr_q] ? rr_q : ~rr_q;
    assign grant_start  = grant_id ? req_start[2*WIDTH-1:WIDTH]  : req_start[WIDTH-1:0];
    assign grant_target = grant_id ? req_target[2*WIDTH-1:WIDTH] : req_target[WIDTH-1:0];
    assign at_target    = (cnt_data_output == target_q);
    assign wd_expired   = (wd_q == WD_LIMIT);

    always_comb begin
        // NOTE: every output is given a default before the case so no path infers a latch.
        req_ready      = 2'b00;
        cnt_enable     = 1'b0;
        cnt_load       = 1'b0;
        cnt_up_down_n  = dir_q;
        cnt_data_input = start_q;
        done_valid     = 1'b0;
        done_id        = 1'b0;
        done_value     = '0;
        done_err       = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_valid) req_ready = grant_id ? 2'b10 : 2'b01;
            end
            LOAD: begin
                cnt_load   = 1'b1;
                cnt_enable = 1'b1;
            end
            // Enable drops in the very cycle the target is seen, so the counter never overshoots.
            COUNT: cnt_enable = !at_target && !wd_expired;
            DONE: begin
                done_valid = 1'b1;
                done_id    = id_q;
                done_value = cnt_data_output;
                done_err   = err_q;
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_q     <= 1'b0;
            id_q     <= 1'b0;
            dir_q    <= 1'b0;
            err_q    <= 1'b0;
            start_q  <= '0;
            target_q <= '0;
            wd_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        id_q     <= grant_id;
                        start_q  <= grant_start;
                        target_q <= grant_target;
                        dir_q    <= (grant_target > grant_start);
                        rr_q     <= ~grant_id;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    wd_q    <= '0;
                    state_q <= COUNT;
                end
                COUNT: begin
                    wd_q <= wd_q + 1'b1;
                    if (at_target) begin
                        err_q   <= 1'b0;
                        state_q <= DONE;
                    end else if (wd_expired) begin
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/counter_cmd_sched.md
# counter_cmd_sched

Round-robin command scheduler that shares one up/down counter between two requesters. Each accepted command loads a start value into the counter and then counts toward a target value. When the counter reaches the target, the block reports completion with a one-cycle pulse. It sits between the requesting agents and the counter's control port, and it is the only driver of that port.

## Interface
- WIDTH, 4, counter data width
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset; the counter shares this net
- req_valid  input  2  per-requester command valid; must hold until accepted
- req_ready  output  2  per-requester accept; a command transfers on valid && ready
- req_start  input  2*WIDTH  start value, requester i at bits [i*WIDTH +: WIDTH]
- req_target  input  2*WIDTH  target value, same packing as req_start
- cnt_enable  output  1  counter enable
- cnt_load  output  1  counter synchronous load
- cnt_up_down_n  output  1  counter direction: 1 = up, 0 = down
- cnt_data_input  output  WIDTH  counter load value
- cnt_data_output  input  WIDTH  counter current value
- done_valid  output  1  one-cycle completion pulse; no backpressure
- done_id  output  1  requester index of the completed command
- done_value  output  WIDTH  cnt_data_output sampled at completion
- done_err  output  1  completion was caused by watchdog timeout

## Operation
- Counter contract:
  - On a clk edge with cnt_load=1 the counter loads cnt_data_input; load has priority.
  - Otherwise, on a clk edge with cnt_enable=1 it steps ±1 according to cnt_up_down_n, wrapping modulo 2^WIDTH.
- FSM states: IDLE, LOAD, COUNT, DONE.
- IDLE:
  - Round-robin arbitration: priority pointer rr starts at 0 (reset value). The winner is the first requesting index at or after rr.
  - req_ready is combinational and equals one-hot(winner) when any req_valid is high, and 0 otherwise.
  - On accept:
    - Capture id, start_q and target_q.
    - Set dir_q = (target > start), unsigned.
    - Set rr = id ^ 1.
    - Go to LOAD.
- LOAD: cnt_load=1, cnt_enable=1, cnt_data_input=start_q. Go to COUNT.
- COUNT:
  - cnt_enable = (cnt_data_output != target_q), combinational, so there is no overshoot.
  - cnt_up_down_n = dir_q.
  - Watchdog counter wd (WIDTH+1 bits) clears on entry and increments every COUNT cycle.
  - When cnt_data_output == target_q, go to DONE with err=0.
  - Otherwise, when wd reaches 2^WIDTH, go to DONE with err=1 and cnt_enable=0 in that cycle.
- DONE:
  - done_valid=1.
  - done_id=id.
  - done_value=cnt_data_output.
  - done_err=err.
  - Go to IDLE.
- Outside LOAD and COUNT: cnt_enable=0, cnt_load=0, cnt_up_down_n=dir_q, cnt_data_input=start_q.
- start == target: no counting steps; COUNT exits on its first cycle.
- A requester whose valid drops before accept is simply not granted; the next request is arbitrated on the following cycle.

## Timing
- Reset values:
  - State IDLE, rr=0, start_q=0, target_q=0, dir_q=0, id=0, err=0, wd=0.
  - All outputs 0, except req_ready, which follows valid in IDLE immediately after reset.
- Reset mid-operation returns to IDLE immediately. No done pulse is issued for the aborted command.
- Let accept be at cycle T and d = |target − start|:
  - LOAD at T+1.
  - Counter holds the start value from T+2.
  - Target is reached at T+2+d.
  - done_valid at T+3+d.
  - Next accept no earlier than T+4+d.
- Each command occupies d+4 cycles including the accept cycle.
- A DONE pulse and a new acceptance never occur in the same cycle.
- Counting never crosses the wrap boundary for valid commands, because direction follows the unsigned compare.
- The watchdog fires only if the counter misbehaves. On timeout, done_valid is at T+3+2^WIDTH.

## Test plan
- After reset, req_valid=2'b01 with start=3, target=7:
  - req_ready=01 in the same cycle.
  - cnt_load at T+1 with data 3.
  - Four enable cycles with up=1.
  - done_valid at T+7 with id=0, value=7, err=0.
- req_valid=2'b11 held continuously, commands start=9 → target=5 for both:
  - Grants alternate 0,1,0,1.
  - Each done has value=5 and direction down.
  - Commands are spaced 8 cycles apart.
- start=target=0xA: no cnt_enable cycles; done at T+3 with value=0xA.
- Counter model stuck (never steps), start=0, target=1: done_err=1 at T+19 and cnt_enable=0 afterwards.
- Assert rst_n low during COUNT of a command 2→12:
  - All outputs go to 0 immediately and no done pulse is issued.
  - After release, a new request for requester 1 alone is granted.
- Boundary values start=0, target=0xF and start=0xF, target=0:
  - 15 steps in each case.
  - done_value is 0xF and 0x0 respectively, with no overshoot observed on cnt_data_output.
